// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: default widths, instruction
// field positions and the memory fetch-unit state type.
package mips_pkg;

  localparam int MIPS_ADDR_W = 16;
  localparam int MIPS_DATA_W = 16;

  // Instruction field positions, also used by the control FSM decoder.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int FUNC_MSB   = 3;
  localparam int FUNC_LSB   = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/mips_mem_fetch_unit.sv
// PC/IR/MDR owner for the multicycle MIPS core; converts FSM memory strobes into
// a req/ready memory transaction. Optional abort-on-timeout: MIPS_MEM_TIMEOUT_EN.
module mips_mem_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W         = MIPS_ADDR_W,
  parameter int                DATA_W         = MIPS_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRwrite,
  input  logic              IorD,
  input  logic              PCWrite,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [3:0]        opcode,
  output logic [3:0]        func_field,
  output logic              stall,
  output logic              mem_err,
  output fetch_state_e      dbg_state
);

  // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are registered and held
  // stable from the request edge until the edge at which mem_ready is sampled
  // high while BUSY; mem_rdata is only taken in that same cycle. mem_ready
  // seen while IDLE carries no transaction and is ignored.

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic              w_start;
  logic              w_done;
  logic              w_timeout;
  logic              w_stall;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ir_cap;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;

`ifdef MIPS_MEM_TIMEOUT_EN
  localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_mem_err;
`else
  logic              w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MemRead | MemWrite) begin
          w_start      = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
`ifdef MIPS_MEM_TIMEOUT_EN
        else if (r_tcnt == TCNT_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A completing or aborting BUSY cycle releases the FSM in that same cycle.
  assign w_stall = w_start | ((r_state == ST_BUSY) & ~w_done & ~w_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ir_cap    <= 1'b0;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_mdr       <= '0;
    end else begin
      if (w_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= MemWrite;
        r_mem_addr  <= IorD ? data_addr : r_pc;
        r_mem_wdata <= wdata;
        // A simultaneous write wins, so the read half never lands in IR.
        r_ir_cap    <= IRwrite & ~MemWrite;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) begin
          r_mdr <= mem_rdata;
          if (r_ir_cap) r_ir <= mem_rdata;
        end
      end else if (w_timeout) begin
        r_mem_req <= 1'b0;
      end
      if (PCWrite && !w_stall) r_pc <= pc_next;
    end
  end

`ifdef MIPS_MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_start)                  r_tcnt <= '0;
      else if (r_state == ST_BUSY)  r_tcnt <= r_tcnt + TCNT_W'(1);
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end
  assign mem_err = r_mem_err;
`else
  assign mem_err = 1'b0;
`endif

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign mdr        = r_mdr;
  assign opcode     = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign func_field = r_ir[FUNC_MSB:FUNC_LSB];
  assign stall      = w_stall;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mips_mem_fetch_unit.sv
// Bench for mips_mem_fetch_unit: directed scenarios plus randomized accesses
// against a word-array memory model. Timeout scenario under MIPS_MEM_TIMEOUT_EN.
module tb_mips_mem_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0, IRwrite = 1'b0, IorD = 1'b0, PCWrite = 1'b0;
  logic [15:0] pc_next = '0, data_addr = '0, wdata = '0, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, pc, ir, mdr;
  logic [3:0]  opcode, func_field;
  fetch_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [0:255];
  logic [15:0] exp_q [$];
  logic [15:0] m_pc, m_ir, m_mdr;

  mips_mem_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .IRwrite(IRwrite),
    .IorD(IorD), .PCWrite(PCWrite), .pc_next(pc_next), .data_addr(data_addr),
    .wdata(wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc), .ir(ir),
    .mdr(mdr), .opcode(opcode), .func_field(func_field), .stall(stall),
    .mem_err(mem_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_strobes();
    MemRead = 1'b0; MemWrite = 1'b0; IRwrite = 1'b0; IorD = 1'b0; PCWrite = 1'b0;
  endtask

  // One complete access; wt = number of BUSY cycles without ready before the ready cycle.
  task automatic do_access(input bit rd, input bit wr, input bit irw, input bit iord,
                           input bit pcw, input logic [15:0] pcn, input logic [15:0] daddr,
                           input logic [15:0] wd, input int wt);
    logic [15:0] ea, rdv;
    int stalls;
    ea = iord ? daddr : m_pc;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; IRwrite = irw; IorD = iord; PCWrite = pcw;
    pc_next = pcn; data_addr = daddr; wdata = wd; mem_ready = 1'b0;
    #1;
    if (stall !== 1'b1) begin checks++; errors++; $display("FAIL start_stall: got %b expected 1", stall); end
    else checks++;
    if (mem_req !== 1'b0) begin checks++; errors++; $display("FAIL start_req: got %b expected 0", mem_req); end
    else checks++;
    stalls = 1;
    @(posedge clk);
    rdv = mem_m[ea[7:0]];
    for (int k = 0; k <= wt; k++) begin
      @(negedge clk);
      mem_ready = (k == wt);
      mem_rdata = (k == wt) ? rdv : 16'($urandom);
      #1;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL busy_req: got %b expected 1", mem_req); end
      checks++;
      if (mem_addr !== ea) begin errors++; $display("FAIL busy_addr: got %h expected %h", mem_addr, ea); end
      checks++;
      if (mem_we !== wr) begin errors++; $display("FAIL busy_we: got %b expected %b", mem_we, wr); end
      checks++;
      if (wr && mem_wdata !== wd) begin errors++; $display("FAIL busy_wdata: got %h expected %h", mem_wdata, wd); end
      if (wr) checks++;
      if (stall !== (k != wt)) begin errors++; $display("FAIL busy_stall: got %b expected %b", stall, (k != wt)); end
      checks++;
      if (pc !== m_pc) begin errors++; $display("FAIL busy_pc: got %h expected %h", pc, m_pc); end
      checks++;
      if (stall === 1'b1) stalls++;
      @(posedge clk);
    end
    if (wr) mem_m[ea[7:0]] = wd;
    else begin
      exp_q.push_back(rdv);
      if (irw) m_ir = rdv;
    end
    if (pcw) m_pc = pcn;
    #1;
    mem_ready = 1'b0;
    if (!wr) m_mdr = exp_q.pop_front();
    if (stalls != 1 + wt) begin errors++; $display("FAIL stall_cycles: got %0d expected %0d", stalls, 1 + wt); end
    checks++;
    if (mdr !== m_mdr) begin errors++; $display("FAIL done_mdr: got %h expected %h", mdr, m_mdr); end
    checks++;
    if (ir !== m_ir) begin errors++; $display("FAIL done_ir: got %h expected %h", ir, m_ir); end
    checks++;
    if (pc !== m_pc) begin errors++; $display("FAIL done_pc: got %h expected %h", pc, m_pc); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL done_req: got %b expected 0", mem_req); end
    checks++;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drop_strobes();
    mem_ready = 1'($urandom);
    mem_rdata = 16'($urandom);
    #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("idle_mdr", {16'd0, mdr}, {16'd0, m_mdr});
    chk("idle_ir", {16'd0, ir}, {16'd0, m_ir});
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drop_strobes();
    repeat (2) @(posedge clk);
    #1;
    m_pc = 16'h0000; m_ir = '0; m_mdr = '0;
    exp_q.delete();
    chk("rst_pc", {16'd0, pc}, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'h0);
    chk("rst_mdr", {16'd0, mdr}, 32'h0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'h0);
    chk("rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch_zero_wait();
    mem_m[0] = 16'h3A05;
    do_access(1, 0, 1, 0, 1, 16'h0001, 16'h0000, 16'h0000, 0);
    chk("fetch_ir", {16'd0, ir}, 32'h3A05);
    chk("fetch_opcode", {28'd0, opcode}, 32'h3);
    chk("fetch_func", {28'd0, func_field}, 32'h5);
    chk("fetch_pc", {16'd0, pc}, 32'h0001);
  endtask

  task automatic test_data_read_wait();
    mem_m[8'h40] = 16'hC3D2;
    do_access(1, 0, 0, 1, 0, 16'h0000, 16'h0040, 16'h0000, 3);
    chk("dread_mdr", {16'd0, mdr}, 32'hC3D2);
    chk("dread_ir_kept", {16'd0, ir}, 32'h3A05);
  endtask

  task automatic test_store();
    do_access(0, 1, 0, 1, 0, 16'h0000, 16'h0010, 16'hBEEF, 2);
    chk("store_mdr_kept", {16'd0, mdr}, 32'hC3D2);
    do_access(1, 1, 1, 1, 0, 16'h0000, 16'h0011, 16'h1234, 1);
    chk("conflict_mdr_kept", {16'd0, mdr}, 32'hC3D2);
    chk("conflict_ir_kept", {16'd0, ir}, 32'h3A05);
    do_access(1, 0, 0, 1, 0, 16'h0000, 16'h0011, 16'h0000, 0);
    chk("conflict_readback", {16'd0, mdr}, 32'h1234);
  endtask

  task automatic test_back_to_back();
    do_access(1, 0, 1, 0, 1, m_pc + 16'd1, 16'h0000, 16'h0000, 0);
    do_access(0, 1, 0, 1, 0, 16'h0000, 16'h0020, 16'h5A5A, 0);
    do_access(1, 0, 0, 1, 1, m_pc + 16'd1, 16'h0020, 16'h0000, 2);
    chk("b2b_mdr", {16'd0, mdr}, 32'h5A5A);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    MemRead = 1'b1; IRwrite = 1'b1; IorD = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drop_strobes();
    @(posedge clk);
    #1;
    m_pc = 16'h0000; m_ir = '0; m_mdr = '0;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_pc", {16'd0, pc}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hFACE;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    chk("midrst_ir", {16'd0, ir}, 32'h0);
    chk("midrst_mdr", {16'd0, mdr}, 32'h0);
    chk("midrst_req_after", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind;
      bit rd, wr, irw, iord;
      kind = int'($urandom_range(0, 3));
      rd = (kind != 2); wr = (kind >= 2);
      irw = (kind == 0) || (kind == 3 && $urandom_range(0, 1) == 1);
      iord = (kind != 0);
      do_access(rd, wr, irw, iord, 1'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), int'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    chk("rand_opcode", {28'd0, opcode}, {28'd0, m_ir[15:12]});
    chk("rand_func", {28'd0, func_field}, {28'd0, m_ir[3:0]});
  endtask

`ifdef MIPS_MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    MemRead = 1'b1; IRwrite = 1'b1; IorD = 1'b1; data_addr = 16'h0077; MemWrite = 1'b0;
    PCWrite = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_stall", {31'd0, stall}, {31'd0, (k != 7)});
      @(posedge clk);
    end
    #1;
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_mdr_kept", {16'd0, mdr}, {16'd0, m_mdr});
    chk("to_ir_kept", {16'd0, ir}, {16'd0, m_ir});
    idle_cycle();
    do_access(1, 0, 0, 1, 0, 16'h0000, 16'h0033, 16'h0000, 1);
    chk("to_err_sticky", {31'd0, mem_err}, 32'd1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 16'($urandom);
    m_pc = '0; m_ir = '0; m_mdr = '0;
    test_reset();
    test_fetch_zero_wait();
    test_data_read_wait();
    test_store();
    idle_cycle();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
`ifdef MIPS_MEM_TIMEOUT_EN
    test_timeout();
`else
    chk("err_tied_low", {31'd0, mem_err}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_fetch_unit.md
Name: mips_mem_fetch_unit

Overview:
Owns the PC, instruction register (IR) and memory data register (MDR) for the multicycle MIPS core, sitting directly upstream of the control FSM.
- Turns the FSM's MemRead/MemWrite/IRwrite/IorD/PCWrite strobes into a req/ready transaction on a variable-latency memory port.
- Feeds opcode/func_field back to the FSM.
- Raises stall to freeze the FSM until each access completes.

Parameters:
- ADDR_W, 16, PC and memory word-address width
- DATA_W, 16, instruction/data word width (opcode = ir[15:12], func = ir[3:0])
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYCLES, 64, BUSY-cycle limit before abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- MemRead  in  1  FSM read strobe, held while stall=1
- MemWrite  in  1  FSM write strobe, held while stall=1
- IRwrite  in  1  capture read data into IR as well as MDR
- IorD  in  1  0: address = pc, 1: address = data_addr
- PCWrite  in  1  load pc_next into PC
- pc_next  in  ADDR_W  next PC from the PC-source mux
- data_addr  in  ADDR_W  ALU result used as data address
- wdata  in  DATA_W  store data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the transaction
- mem_req  out  1  request valid, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- pc  out  ADDR_W  program counter
- ir  out  DATA_W  instruction register
- mdr  out  DATA_W  memory data register
- opcode  out  4  ir[15:12]
- func_field  out  4  ir[3:0]
- stall  out  1  combinational; FSM must hold state while high
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset values: pc=RESET_PC; ir=0; mdr=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_err=0; state=IDLE.
- Reset mid-transaction: drops mem_req at the same edge. A mem_ready arriving after reset is ignored.
- States: IDLE, BUSY.
- IDLE, when MemRead|MemWrite:
  - latch mem_addr (IorD ? data_addr : pc), mem_we=MemWrite, mem_wdata=wdata, ir_cap=IRwrite & ~MemWrite;
  - set mem_req=1; go to BUSY.
- Read/write conflict: if MemRead and MemWrite are both high, the write wins and the read is dropped.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable.
  - On mem_ready: mem_req=0; on a read, mdr<=mem_rdata, and ir<=mem_rdata if ir_cap; go to IDLE.
- mem_ready in IDLE is ignored.
- stall = (IDLE & (MemRead|MemWrite)) | (BUSY & ~mem_ready).
- Latency: minimum 2 cycles (request cycle + ready cycle). Data is visible in mdr/ir the cycle after mem_ready.
- Back-to-back accesses: the FSM re-asserting a strobe in the cycle after completion starts a new transaction with no idle gap.
- PC update: pc <= pc_next only when PCWrite & ~stall, so a stalled FSM cannot double-increment. PCWrite in the same cycle as completion is honoured.
- opcode and func_field are continuous slices of ir.

Optional Feature:
- Macro MIPS_MEM_TIMEOUT_EN.
- Defined:
  - a counter clears on entering BUSY and increments every BUSY cycle;
  - when it reaches TIMEOUT_CYCLES-1 without mem_ready: abort to IDLE, mem_req=0, mdr/ir unchanged, mem_err<=1 (sticky until rst);
  - stall drops in that cycle.
- Undefined: no counter, mem_err tied 0, BUSY waits indefinitely.

Decomposition:
- Shared package mips_pkg:
  - ADDR_W and DATA_W defaults;
  - opcode/func bit-position constants;
  - fetch state typedef (IDLE, BUSY).
- The control FSM reuses the opcode/func constants.
- No sub-module. The timeout counter is inline, under the macro.

Test Plan:
- rst held 2 cycles -> pc=0000, mem_req=0, stall=0, ir=0, mem_err=0.
- Fetch, zero wait: MemRead=1, IRwrite=1, IorD=0, pc=0000, memory returns 16'h3A05 with ready on the first BUSY cycle -> mem_req high 1 cycle; stall high 1 cycle; ir=3A05, opcode=3, func_field=5; pc loads pc_next=0001 only on the non-stalled cycle.
- Data read, 4-cycle wait: IorD=1, data_addr=0040, ready after 4 BUSY cycles -> mem_addr=0040 stable throughout; stall high 4 cycles; mdr=rdata; ir unchanged.
- Store: MemWrite=1, data_addr=0010, wdata=BEEF -> mem_we=1, mem_wdata=BEEF, mdr unchanged. With MemRead and MemWrite both high -> write only.
- rst asserted mid-BUSY, then mem_ready pulsed -> mem_req drops at reset edge; ir/mdr stay 0.
- With MIPS_MEM_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, mem_ready never asserted -> abort after 8 BUSY cycles; mem_err=1 sticky; stall=0; next request proceeds normally.
